// File: rtl/high_bit_expand_pkg.sv
// Shared sizing helpers for the high-bit search / expand pair.
// Both ends derive tree depth and padded width from the same functions,
// so an encoder and its matching decoder always agree on the index layout.
package high_bit_expand_pkg;

   localparam int unsigned HB_DEFAULT_WIDTH = 8;

   // Number of tree levels. A 2-bit vector still needs one doubling stage.
   function automatic int unsigned hb_levels(input int unsigned width);
      if (width > 2) begin
         return $clog2(width);
      end
      return 1;
   endfunction

   // Internal power-of-2 vector width produced by the tree.
   function automatic int unsigned hb_width_padded(input int unsigned width);
      return 32'd1 << hb_levels(width);
   endfunction

   // Bit-index type for the default vector width.
   typedef logic [$clog2(HB_DEFAULT_WIDTH)-1:0] hb_index_t;

endpackage : high_bit_expand_pkg

// File: rtl/high_bit_expand_stage.sv
// One level of the index-to-mask decode tree.
// Doubles the one-hot / thermometer vectors using one index bit and
// registers the result, together with the sideband that travels with the beat.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en_i         pipeline advance; every register holds when low
//   valid_i/o    beat valid in / registered out
//   flag_i/o     bit-present flag in / registered out
//   rerr_i/o     range-error bit in / registered out
//   idx_i/o      zero-extended index in / registered out
//   oh_i, mk_i   one-hot and mask from the previous level (IN_W bits)
//   oh_o, mk_o   doubled one-hot and mask, registered (2*IN_W bits)
module high_bit_expand_stage
   import high_bit_expand_pkg::*;
#(
   parameter int unsigned IN_W    = 1,
   parameter int unsigned IDX_W   = 1,
   parameter int unsigned BIT_SEL = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en_i,
   input  logic                valid_i,
   input  logic                flag_i,
   input  logic                rerr_i,
   input  logic [IDX_W-1:0]    idx_i,
   input  logic [IN_W-1:0]     oh_i,
   input  logic [IN_W-1:0]     mk_i,
   output logic                valid_o,
   output logic                flag_o,
   output logic                rerr_o,
   output logic [IDX_W-1:0]    idx_o,
   output logic [2*IN_W-1:0]   oh_o,
   output logic [2*IN_W-1:0]   mk_o
);

   logic                b;
   logic [2*IN_W-1:0]   oh_d, mk_d;
   logic [2*IN_W-1:0]   oh_q, mk_q;
   logic                valid_q, flag_q, rerr_q;
   logic [IDX_W-1:0]    idx_q;

   assign b = idx_i[BIT_SEL];

   // Each parent bit splits into a low/high child. The high child of the
   // mask is cleared only when the parent is the selected bit and b picks
   // the low half, so every bit below the selected one stays set.
   always_comb begin
      oh_d = '0;
      mk_d = '0;
      for (int unsigned j = 0; j < IN_W; j++) begin
         oh_d[2*j+1] = oh_i[j] & b;
         oh_d[2*j]   = oh_i[j] & ~b;
         mk_d[2*j+1] = mk_i[j] & (~oh_i[j] | b);
         mk_d[2*j]   = mk_i[j];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         flag_q  <= 1'b0;
         rerr_q  <= 1'b0;
         idx_q   <= '0;
         oh_q    <= '0;
         mk_q    <= '0;
      end else if (en_i) begin
         valid_q <= valid_i;
         flag_q  <= flag_i;
         rerr_q  <= rerr_i;
         idx_q   <= idx_i;
         oh_q    <= oh_d;
         mk_q    <= mk_d;
      end
   end

   assign valid_o = valid_q;
   assign flag_o  = flag_q;
   assign rerr_o  = rerr_q;
   assign idx_o   = idx_q;
   assign oh_o    = oh_q;
   assign mk_o    = mk_q;

endmodule : high_bit_expand_stage

// File: rtl/high_bit_expand.sv
// Pipelined binary-to-mask decoder (inverse of the high-bit search encoder).
// Decodes a bit index into a one-hot vector and a thermometer mask covering
// that bit and all lower bits, through a log2 tree of registered stages.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_valid       input beat valid
//   in_ready       input beat accepted when in_valid & in_ready
//   in_flag        a bit is present (encoder's valid flag)
//   in_index       bit position to decode
//   out_valid      output beat valid
//   out_ready      downstream accepts output
//   out_flag       registered copy of in_flag
//   out_onehot     one-hot of in_index
//   out_mask       bits [in_index:0] set
//   out_range_err  in_index >= OUTPUT_WIDTH with in_flag set
module high_bit_expand
   import high_bit_expand_pkg::*;
#(
   parameter int unsigned OUTPUT_WIDTH = 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic                                 in_flag,
   input  logic [$clog2(OUTPUT_WIDTH)-1:0]      in_index,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 out_flag,
   output logic [OUTPUT_WIDTH-1:0]              out_onehot,
   output logic [OUTPUT_WIDTH-1:0]              out_mask,
   output logic                                 out_range_err
);

   localparam int unsigned IDX_WIDTH    = $clog2(OUTPUT_WIDTH);
   localparam int unsigned LEVELS       = hb_levels(OUTPUT_WIDTH);
   localparam int unsigned WIDTH_PADDED = hb_width_padded(OUTPUT_WIDTH);

   // Level s occupies bits [2**s-1 +: 2**s] of the flat vectors; level 0 is
   // the 1-bit seed taken straight from the inputs.
   logic [2*WIDTH_PADDED-2:0]      oh_all, mk_all;
   logic [(LEVELS+1)*LEVELS-1:0]   idx_all;
   logic [LEVELS:0]                valid_all, flag_all, rerr_all;
   logic                           advance;
   logic                           rerr_in;

   assign advance  = !out_valid | out_ready;
   assign in_ready = advance;

   assign rerr_in = in_flag & (32'(in_index) >= OUTPUT_WIDTH);

   assign oh_all[0]               = in_flag;
   assign mk_all[0]               = in_flag;
   assign idx_all[0 +: LEVELS]    = LEVELS'(in_index);
   assign valid_all[0]            = in_valid;
   assign flag_all[0]             = in_flag;
   assign rerr_all[0]             = rerr_in;

   for (genvar s = 1; s <= LEVELS; s++) begin : g_level
      localparam int unsigned IN_W = 32'd1 << (s - 1);

      high_bit_expand_stage #(
         .IN_W    (IN_W),
         .IDX_W   (LEVELS),
         .BIT_SEL (LEVELS - s)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .en_i    (advance),
         .valid_i (valid_all[s-1]),
         .flag_i  (flag_all[s-1]),
         .rerr_i  (rerr_all[s-1]),
         .idx_i   (idx_all[(s-1)*LEVELS +: LEVELS]),
         .oh_i    (oh_all[IN_W-1 +: IN_W]),
         .mk_i    (mk_all[IN_W-1 +: IN_W]),
         .valid_o (valid_all[s]),
         .flag_o  (flag_all[s]),
         .rerr_o  (rerr_all[s]),
         .idx_o   (idx_all[s*LEVELS +: LEVELS]),
         .oh_o    (oh_all[2*IN_W-1 +: 2*IN_W]),
         .mk_o    (mk_all[2*IN_W-1 +: 2*IN_W])
      );
   end

   logic [WIDTH_PADDED-1:0] oh_fin, mk_fin;
   logic [LEVELS-1:0]       idx_fin_unused;

   assign oh_fin         = oh_all[WIDTH_PADDED-1 +: WIDTH_PADDED];
   assign mk_fin         = mk_all[WIDTH_PADDED-1 +: WIDTH_PADDED];
   assign idx_fin_unused = idx_all[LEVELS*LEVELS +: LEVELS];

   // Truncating the padded tree gives onehot=0 / mask=all-ones for an
   // out-of-range index on non-power-of-2 widths.
   if (OUTPUT_WIDTH < WIDTH_PADDED) begin : g_pad
      logic pad_unused;
      assign pad_unused = ^{oh_fin[WIDTH_PADDED-1:OUTPUT_WIDTH],
                            mk_fin[WIDTH_PADDED-1:OUTPUT_WIDTH]};
   end

   assign out_valid     = valid_all[LEVELS];
   assign out_flag      = flag_all[LEVELS];
   assign out_range_err = rerr_all[LEVELS];
   assign out_onehot    = oh_fin[OUTPUT_WIDTH-1:0];
   assign out_mask      = mk_fin[OUTPUT_WIDTH-1:0];

endmodule : high_bit_expand

// File: tb/tb_high_bit_expand.sv
// Bench for high_bit_expand: an 8-wide and a 6-wide instance, table-driven
// vectors checked through per-instance expected-result queues, plus
// hand-written latency, backpressure and mid-stream reset sequences.
module tb_high_bit_expand;
   import high_bit_expand_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 8-wide instance
   logic       v8, r8, f8, ordy8, ov8, of8, re8;
   logic [2:0] idx8;
   logic [7:0] oh8, mk8;
   // 6-wide instance
   logic       v6, r6, f6, ordy6, ov6, of6, re6;
   logic [2:0] idx6;
   logic [5:0] oh6, mk6;

   high_bit_expand #(.OUTPUT_WIDTH(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_flag(f8),
      .in_index(idx8), .out_valid(ov8), .out_ready(ordy8), .out_flag(of8),
      .out_onehot(oh8), .out_mask(mk8), .out_range_err(re8));

   high_bit_expand #(.OUTPUT_WIDTH(6)) u_d6 (
      .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(r6), .in_flag(f6),
      .in_index(idx6), .out_valid(ov6), .out_ready(ordy6), .out_flag(of6),
      .out_onehot(oh6), .out_mask(mk6), .out_range_err(re6));

   typedef struct {
      logic       flag;
      logic [2:0] idx;
      logic [7:0] oh;
      logic [7:0] mk;
      logic       re;
   } vec_t;

   typedef struct {
      logic       flag;
      logic [7:0] oh;
      logic [7:0] mk;
      logic       re;
   } exp_t;

   exp_t q8[$];
   exp_t q6[$];

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned n_out8 = 0;
   int unsigned n_out6 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Output side: every valid&ready cycle is one transfer, popped in order.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && ov8 && ordy8) begin
         if (q8.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL d8_extra_beat: got onehot %0h expected no beat", oh8);
         end else begin
            e = q8.pop_front();
            chk("d8_flag",   32'(of8), 32'(e.flag));
            chk("d8_onehot", 32'(oh8), 32'(e.oh));
            chk("d8_mask",   32'(mk8), 32'(e.mk));
            chk("d8_rerr",   32'(re8), 32'(e.re));
            n_out8++;
         end
      end
      if (rst_n && ov6 && ordy6) begin
         if (q6.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL d6_extra_beat: got onehot %0h expected no beat", oh6);
         end else begin
            e = q6.pop_front();
            chk("d6_flag",   32'(of6), 32'(e.flag));
            chk("d6_onehot", 32'(oh6), 32'(e.oh));
            chk("d6_mask",   32'(mk6), 32'(e.mk));
            chk("d6_rerr",   32'(re6), 32'(e.re));
            n_out6++;
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input bit sel6, input vec_t v, output int unsigned waits);
      logic rdy;
      waits = 0;
      if (sel6) begin v6 = 1'b1; f6 = v.flag; idx6 = v.idx; end
      else      begin v8 = 1'b1; f8 = v.flag; idx8 = v.idx; end
      while (1) begin
         @(negedge clk);
         rdy = sel6 ? r6 : r8;
         if (rdy) begin
            if (sel6) q6.push_back('{v.flag, v.oh, v.mk, v.re});
            else      q8.push_back('{v.flag, v.oh, v.mk, v.re});
            break;
         end
         waits++;
         if (waits >= 50) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected acceptance", waits);
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic cycles(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   vec_t tab8[9];
   vec_t tab6[5];
   vec_t bp[3];
   vec_t one;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected completion within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned w, wsum, base;

      // Index sweep 0..7 then an absent-bit beat.
      tab8[0] = '{1'b1, 3'd0, 8'h01, 8'h01, 1'b0};
      tab8[1] = '{1'b1, 3'd1, 8'h02, 8'h03, 1'b0};
      tab8[2] = '{1'b1, 3'd2, 8'h04, 8'h07, 1'b0};
      tab8[3] = '{1'b1, 3'd3, 8'h08, 8'h0F, 1'b0};
      tab8[4] = '{1'b1, 3'd4, 8'h10, 8'h1F, 1'b0};
      tab8[5] = '{1'b1, 3'd5, 8'h20, 8'h3F, 1'b0};
      tab8[6] = '{1'b1, 3'd6, 8'h40, 8'h7F, 1'b0};
      tab8[7] = '{1'b1, 3'd7, 8'h80, 8'hFF, 1'b0};
      tab8[8] = '{1'b0, 3'd6, 8'h00, 8'h00, 1'b0};
      // 6-wide: out-of-range, top bit, middle, absent, bottom.
      tab6[0] = '{1'b1, 3'd7, 8'h00, 8'h3F, 1'b1};
      tab6[1] = '{1'b1, 3'd5, 8'h20, 8'h3F, 1'b0};
      tab6[2] = '{1'b1, 3'd3, 8'h08, 8'h0F, 1'b0};
      tab6[3] = '{1'b0, 3'd7, 8'h00, 8'h00, 1'b0};
      tab6[4] = '{1'b1, 3'd0, 8'h01, 8'h01, 1'b0};
      bp[0]   = '{1'b1, 3'd2, 8'h04, 8'h07, 1'b0};
      bp[1]   = '{1'b1, 3'd4, 8'h10, 8'h1F, 1'b0};
      bp[2]   = '{1'b1, 3'd6, 8'h40, 8'h7F, 1'b0};

      rst_n = 1'b0;
      v8 = 1'b0; f8 = 1'b0; idx8 = '0; ordy8 = 1'b1;
      v6 = 1'b0; f6 = 1'b0; idx6 = '0; ordy6 = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_ov8",  32'(ov8), 32'd0);
      chk("rst_oh8",  32'(oh8), 32'd0);
      chk("rst_mk8",  32'(mk8), 32'd0);
      chk("rst_of8",  32'(of8), 32'd0);
      chk("rst_re8",  32'(re8), 32'd0);
      chk("rst_rdy8", 32'(r8),  32'd1);
      chk("rst_ov6",  32'(ov6), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycles(1);

      // Latency: index 5 appears exactly three cycles after acceptance.
      send(1'b0, tab8[5], w);
      v8 = 1'b0;
      @(negedge clk); chk("lat_c1_ov", 32'(ov8), 32'd0);
      @(negedge clk); chk("lat_c2_ov", 32'(ov8), 32'd0);
      @(negedge clk); chk("lat_c3_ov", 32'(ov8), 32'd1);
      @(posedge clk); #1;
      cycles(2);
      chk("lat_drain", 32'(q8.size()), 32'd0);

      // Back-to-back sweep: no stall, one result per cycle, in order.
      base = n_out8;
      wsum = 0;
      for (int i = 0; i < 9; i++) begin
         send(1'b0, tab8[i], w);
         wsum += w;
      end
      v8 = 1'b0;
      cycles(5);
      chk("sweep_stalls", wsum, 32'd0);
      chk("sweep_beats",  n_out8 - base, 32'd9);
      chk("sweep_drain",  32'(q8.size()), 32'd0);

      // Backpressure: three beats in flight, downstream stalled 4 cycles.
      ordy8 = 1'b0;
      base = n_out8;
      for (int i = 0; i < 3; i++) send(1'b0, bp[i], w);
      v8 = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(r8),  32'd0);
         chk("bp_ov",       32'(ov8), 32'd1);
         chk("bp_oh_hold",  32'(oh8), 32'h04);
         chk("bp_mk_hold",  32'(mk8), 32'h07);
      end
      @(posedge clk); #1;
      ordy8 = 1'b1;
      cycles(6);
      chk("bp_beats", n_out8 - base, 32'd3);
      chk("bp_drain", 32'(q8.size()), 32'd0);

      // Non-power-of-2 width, including out-of-range index.
      base = n_out6;
      for (int i = 0; i < 5; i++) send(1'b1, tab6[i], w);
      v6 = 1'b0;
      cycles(5);
      chk("w6_beats", n_out6 - base, 32'd5);
      chk("w6_drain", 32'(q6.size()), 32'd0);

      // Asynchronous reset with two beats in flight.
      one = tab8[3];
      send(1'b0, one, w);
      one = tab8[6];
      send(1'b0, one, w);
      v8 = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ov",  32'(ov8), 32'd0);
      chk("arst_oh",  32'(oh8), 32'd0);
      chk("arst_mk",  32'(mk8), 32'd0);
      chk("arst_of",  32'(of8), 32'd0);
      chk("arst_re",  32'(re8), 32'd0);
      q8.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("arst_no_stale", 32'(ov8), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_high_bit_expand
